// File: rtl/io_pkg.sv
// io_pkg -- shared definitions for the io_responder block.
//   * DEFAULT_BASE_ADDR : default base of the 16-word register window
//   * reg_off_e         : register offsets inside the window
//   * ST_*              : bit positions inside the STATUS register
//   * pack_status()     : assembles the STATUS read value
package io_pkg;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFF00;

  typedef enum logic [3:0] {
    OFF_OUT0   = 4'h0,
    OFF_OUT1   = 4'h1,
    OFF_RXDATA = 4'h2,
    OFF_STATUS = 4'h3,
    OFF_TIMER  = 4'h4
  } reg_off_e;

  localparam int ST_EMPTY      = 0;
  localparam int ST_FULL       = 1;
  localparam int ST_OVERFLOW   = 2;
  localparam int ST_TIMER_DONE = 3;
  localparam int ST_COUNT_LSB  = 4;

  // Width of the FIFO occupancy count; holds 0..8.
  localparam int CNT_W = 4;

  function automatic logic [15:0] pack_status(
    input logic             empty,
    input logic             full,
    input logic             overflow,
    input logic             timer_done,
    input logic [CNT_W-1:0] count
  );
    logic [15:0] s;
    s                           = '0;
    s[ST_EMPTY]                 = empty;
    s[ST_FULL]                  = full;
    s[ST_OVERFLOW]              = overflow;
    s[ST_TIMER_DONE]            = timer_done;
    s[ST_COUNT_LSB +: CNT_W]    = count;
    return s;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// io_fifo -- small receive FIFO with first-word-fall-through head output.
// Ports:
//   clk, reset      clock, synchronous active-low reset (pointers/count only)
//   push, wdata     write request and data (ignored when full)
//   pop             remove head word (ignored when empty)
//   head            current head word, valid whenever empty is low
//   full, empty     occupancy flags
//   count           number of stored words
module io_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [15:0]      wdata,
  input  logic             pop,
  output logic [15:0]      head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0]      mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // The head is read combinationally so a pop can return the word in the
  // same cycle it is requested; the array therefore maps to distributed RAM.
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wdata;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// io_responder -- memory-mapped IO block: two output registers, a receive
// FIFO fed by an external producer, a down-counting timer and an interrupt.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   addr, wdata, we, oe   CPU bus (16-word window at BASE_ADDR)
//   rdata, rvalid         registered read return, one cycle after oe
//   in_data, in_valid     producer side of the receive FIFO
//   in_ready              FIFO not full (forced low during reset)
//   out0, out1            output port registers
//   irq                   registered timer_done | FIFO not empty
module io_responder
  import io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        we,
  input  logic        oe,
  output logic [15:0] rdata,
  output logic        rvalid,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out0,
  output logic [15:0] out1,
  output logic        irq
);

  logic [15:0]      out0_reg, out1_reg, timer_reg, rdata_reg;
  logic             rvalid_reg, irq_reg, overflow_reg, timer_done_reg;
  logic             sel, wr, rd;
  logic [3:0]       off;
  logic [15:0]      read_value;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [15:0]      fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             timer_write, timer_expire, status_write;

  assign sel = (addr[15:4] == BASE_ADDR[15:4]);
  assign off = addr[3:0];
  assign wr  = sel && we;
  assign rd  = sel && oe;

  assign in_ready  = reset && !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign fifo_pop  = rd && (off == OFF_RXDATA) && !fifo_empty;

  assign timer_write  = wr && (off == OFF_TIMER);
  assign status_write = wr && (off == OFF_STATUS);
  // Only a genuine count-down from 1 marks expiry; a write overrides it.
  assign timer_expire = !timer_write && (timer_reg == 16'd1);

  io_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata (in_data),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Read data is taken from the current (pre-write) state of every register.
  always_comb begin
    read_value = '0;
    case (off)
      OFF_OUT0:   read_value = out0_reg;
      OFF_OUT1:   read_value = out1_reg;
      OFF_RXDATA: read_value = fifo_empty ? 16'h0000 : fifo_head;
      OFF_STATUS: read_value = pack_status(fifo_empty, fifo_full, overflow_reg,
                                           timer_done_reg, fifo_count);
      OFF_TIMER:  read_value = timer_reg;
      default:    read_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out0_reg       <= '0;
      out1_reg       <= '0;
      timer_reg      <= '0;
      rdata_reg      <= '0;
      rvalid_reg     <= 1'b0;
      irq_reg        <= 1'b0;
      overflow_reg   <= 1'b0;
      timer_done_reg <= 1'b0;
    end else begin
      rvalid_reg <= rd;
      if (rd) rdata_reg <= read_value;

      if (wr && (off == OFF_OUT0)) out0_reg <= wdata;
      if (wr && (off == OFF_OUT1)) out1_reg <= wdata;

      if (timer_write) begin
        timer_reg <= wdata;
      end else if (timer_reg != 16'd0) begin
        timer_reg <= timer_reg - 16'd1;
      end

      // Sticky bits: a new event in the same cycle as a clear wins.
      if (status_write && wdata[ST_OVERFLOW])   overflow_reg   <= 1'b0;
      if (in_valid && fifo_full)                overflow_reg   <= 1'b1;
      if (status_write && wdata[ST_TIMER_DONE]) timer_done_reg <= 1'b0;
      if (timer_expire)                         timer_done_reg <= 1'b1;

      irq_reg <= timer_done_reg || !fifo_empty;
    end
  end

  assign rdata  = rdata_reg;
  assign rvalid = rvalid_reg;
  assign out0   = out0_reg;
  assign out1   = out1_reg;
  assign irq    = irq_reg;

endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder -- self-checking bench for io_responder: a vector table,
// hand-written multi-cycle sequences and a randomized phase, all shadowed by
// a queue-based reference model.
module tb_io_responder;

  localparam logic [15:0] BASE  = 16'hFF00;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] addr = '0, wdata = '0, in_data = '0;
  logic        we = 1'b0, oe = 1'b0, in_valid = 1'b0;
  logic [15:0] rdata, out0, out1;
  logic        rvalid, in_ready, irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  io_responder #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .oe       (oe),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out0     (out0),
    .out1     (out1),
    .irq      (irq)
  );

  // ---------------- reference model ----------------
  logic [15:0] q[$];
  logic [15:0] m_out0 = '0, m_out1 = '0, m_timer = '0, m_rdata = '0;
  logic        m_rvalid = 1'b0, m_irq = 1'b0, m_done = 1'b0, m_ovf = 1'b0;

  task automatic model_step();
    int          n;
    logic        s;
    logic [3:0]  o;
    logic [15:0] v;
    if (!reset) begin
      m_out0 = '0; m_out1 = '0; m_timer = '0; m_rdata = '0;
      m_rvalid = 1'b0; m_irq = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
      q.delete();
      return;
    end
    s = (addr[15:4] == BASE[15:4]);
    o = addr[3:0];
    n = q.size();
    m_irq = m_done || (n != 0);
    if (s && oe) begin
      case (o)
        4'h0:    v = m_out0;
        4'h1:    v = m_out1;
        4'h2:    v = (n != 0) ? q[0] : 16'h0000;
        4'h3:    v = {8'h00, 4'(n), m_done, m_ovf, (n == DEPTH), (n == 0)};
        4'h4:    v = m_timer;
        default: v = 16'h0000;
      endcase
      m_rdata  = v;
      m_rvalid = 1'b1;
      if (o == 4'h2 && n != 0) void'(q.pop_front());
    end else begin
      m_rvalid = 1'b0;
    end
    if (s && we && o == 4'h3 && wdata[2]) m_ovf = 1'b0;
    if (s && we && o == 4'h3 && wdata[3]) m_done = 1'b0;
    if (in_valid) begin
      if (n < DEPTH) q.push_back(in_data);
      else           m_ovf = 1'b1;
    end
    if (s && we && o == 4'h4) begin
      m_timer = wdata;
    end else if (m_timer != 0) begin
      if (m_timer == 1) m_done = 1'b1;
      m_timer = m_timer - 1;
    end
    if (s && we && o == 4'h0) m_out0 = wdata;
    if (s && we && o == 4'h1) m_out1 = wdata;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clk);
    #1;
    if (we || oe || !reset)
      $display("[%0t] %s rst=%b addr=%h we=%b oe=%b wdata=%h -> rdata=%h rvalid=%b",
               $time, tag, reset, addr, we, oe, wdata, rdata, rvalid);
    chk({tag, ".rdata"},    rdata,    m_rdata);
    chk({tag, ".rvalid"},   16'(rvalid), 16'(m_rvalid));
    chk({tag, ".irq"},      16'(irq), 16'(m_irq));
    chk({tag, ".out0"},     out0,     m_out0);
    chk({tag, ".out1"},     out1,     m_out1);
    chk({tag, ".in_ready"}, 16'(in_ready), 16'(reset && (q.size() < DEPTH)));
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d, input string tag);
    addr = a; wdata = d; we = 1'b1;
    step(tag);
    we = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    addr = a; oe = 1'b1;
    step(tag);
    oe = 1'b0;
    chk({tag, ".const_rdata"}, rdata, exp);
    chk({tag, ".const_rvalid"}, 16'(rvalid), 16'd1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        rst;
    logic [15:0] a, d;
    logic        w, r, iv;
    logic [15:0] id;
    logic        erv;
    logic [15:0] erd, eo0, eo1;
    logic        erdy, eirq;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic rst, logic [15:0] a, logic [15:0] d, logic w, logic r,
                              logic iv, logic [15:0] id, logic erv, logic [15:0] erd,
                              logic [15:0] eo0, logic [15:0] eo1, logic erdy, logic eirq);
    vec_t t;
    t.rst = rst; t.a = a; t.d = d; t.w = w; t.r = r; t.iv = iv; t.id = id;
    t.erv = erv; t.erd = erd; t.eo0 = eo0; t.eo1 = eo1; t.erdy = erdy; t.eirq = eirq;
    return t;
  endfunction

  logic [15:0] exp_words[4];

  initial begin
    //            rst addr      wdata    we oe iv in_data  rv rdata    out0     out1     rdy irq
    tbl[0]  = mk(0, 16'hFF00, 16'hBEEF, 1, 0, 1, 16'h00A0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    tbl[1]  = mk(1, 16'hFF00, 16'hBEEF, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'hBEEF, 16'h0000, 1, 0);
    tbl[2]  = mk(1, 16'hFF01, 16'h1234, 1, 0, 0, 16'h0000, 0, 16'h0000, 16'hBEEF, 16'h1234, 1, 0);
    tbl[3]  = mk(1, 16'hFF00, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'hBEEF, 16'hBEEF, 16'h1234, 1, 0);
    tbl[4]  = mk(1, 16'hFF01, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h1234, 16'hBEEF, 16'h1234, 1, 0);
    tbl[5]  = mk(1, 16'hFF00, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h1234, 16'hBEEF, 16'h1234, 1, 0);
    tbl[6]  = mk(1, 16'hFE00, 16'h5555, 1, 0, 0, 16'h0000, 0, 16'h1234, 16'hBEEF, 16'h1234, 1, 0);
    tbl[7]  = mk(1, 16'hFE00, 16'h0000, 0, 1, 0, 16'h0000, 0, 16'h1234, 16'hBEEF, 16'h1234, 1, 0);
    tbl[8]  = mk(1, 16'hFF07, 16'h7777, 1, 0, 0, 16'h0000, 0, 16'h1234, 16'hBEEF, 16'h1234, 1, 0);
    tbl[9]  = mk(1, 16'hFF07, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0000, 16'hBEEF, 16'h1234, 1, 0);
    tbl[10] = mk(1, 16'hFF00, 16'h0042, 1, 1, 0, 16'h0000, 1, 16'hBEEF, 16'h0042, 16'h1234, 1, 0);
    tbl[11] = mk(1, 16'hFF00, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0042, 16'h0042, 16'h1234, 1, 0);
    tbl[12] = mk(1, 16'hFF03, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h0001, 16'h0042, 16'h1234, 1, 0);
    tbl[13] = mk(1, 16'hFF00, 16'h0000, 0, 0, 1, 16'h00A1, 0, 16'h0001, 16'h0042, 16'h1234, 1, 0);
    tbl[14] = mk(1, 16'hFF00, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h0001, 16'h0042, 16'h1234, 1, 1);
    tbl[15] = mk(1, 16'hFF02, 16'h0000, 0, 1, 0, 16'h0000, 1, 16'h00A1, 16'h0042, 16'h1234, 1, 1);
    tbl[16] = mk(1, 16'hFF00, 16'h0000, 0, 0, 0, 16'h0000, 0, 16'h00A1, 16'h0042, 16'h1234, 1, 0);

    for (int i = 0; i < 17; i++) begin
      reset = tbl[i].rst; addr = tbl[i].a; wdata = tbl[i].d;
      we = tbl[i].w; oe = tbl[i].r; in_valid = tbl[i].iv; in_data = tbl[i].id;
      step($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.rvalid_c", i),   16'(rvalid),   16'(tbl[i].erv));
      chk($sformatf("tbl%0d.rdata_c", i),    rdata,         tbl[i].erd);
      chk($sformatf("tbl%0d.out0_c", i),     out0,          tbl[i].eo0);
      chk($sformatf("tbl%0d.out1_c", i),     out1,          tbl[i].eo1);
      chk($sformatf("tbl%0d.in_ready_c", i), 16'(in_ready), 16'(tbl[i].erdy));
      chk($sformatf("tbl%0d.irq_c", i),      16'(irq),      16'(tbl[i].eirq));
    end
    we = 1'b0; oe = 1'b0; in_valid = 1'b0;

    // ---- overflow: fill, one extra word, drain, read when empty ----
    exp_words[0] = 16'h00A1; exp_words[1] = 16'h00A2;
    exp_words[2] = 16'h00A3; exp_words[3] = 16'h00A4;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = exp_words[i];
      step($sformatf("push%0d", i));
    end
    chk("full.in_ready", 16'(in_ready), 16'd0);
    in_data = 16'h00A5;
    step("push_over");
    in_valid = 1'b0;
    bus_rd(16'hFF03, 16'h0046, "status_full_ovf");
    for (int i = 0; i < 4; i++) bus_rd(16'hFF02, exp_words[i], $sformatf("pop%0d", i));
    bus_rd(16'hFF02, 16'h0000, "pop_empty");
    bus_rd(16'hFF03, 16'h0005, "status_empty_ovf");
    bus_wr(16'hFF03, 16'h0004, "clr_ovf");
    bus_rd(16'hFF03, 16'h0001, "status_clr_ovf");

    // ---- simultaneous push/pop at count 2, across pointer wrap ----
    in_valid = 1'b1; in_data = 16'h00B1; step("pushB1");
    in_data = 16'h00B2; step("pushB2");
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 16'h00B3 + 16'(i);
      bus_rd(16'hFF02, 16'h00B1 + 16'(i), $sformatf("pushpop%0d", i));
    end
    in_valid = 1'b0;
    bus_rd(16'hFF03, 16'h0020, "status_cnt2");
    bus_rd(16'hFF02, 16'h00B5, "popB5");
    bus_rd(16'hFF02, 16'h00B6, "popB6");
    bus_rd(16'hFF03, 16'h0001, "status_drained");

    // ---- timer count-down, done flag, irq and clear ----
    bus_wr(16'hFF04, 16'd3, "timer_load3");
    step("timer_idle");
    for (int i = 0; i < 3; i++) bus_rd(16'hFF04, 16'(2 - i), $sformatf("timer_rd%0d", i));
    chk("timer.irq_set", 16'(irq), 16'd1);
    bus_rd(16'hFF03, 16'h0009, "status_done");
    bus_wr(16'hFF03, 16'h0008, "clr_done");
    step("done_idle");
    chk("timer.irq_clr", 16'(irq), 16'd0);
    bus_rd(16'hFF03, 16'h0001, "status_done_clr");
    bus_wr(16'hFF04, 16'd0, "timer_load0");
    step("t0_idle");
    bus_rd(16'hFF03, 16'h0001, "status_load0");

    // ---- reset with FIFO count 3 and TIMER 10 ----
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 16'h00C1 + 16'(i);
      step($sformatf("pushC%0d", i));
    end
    in_valid = 1'b0;
    bus_wr(16'hFF04, 16'd10, "timer_load10");
    reset = 1'b0; in_valid = 1'b1; in_data = 16'h00C4;
    step("reset_pulse");
    chk("rst.out0", out0, 16'h0000);
    chk("rst.out1", out1, 16'h0000);
    chk("rst.in_ready", 16'(in_ready), 16'd0);
    chk("rst.irq", 16'(irq), 16'd0);
    reset = 1'b1; in_valid = 1'b0;
    step("post_reset");
    chk("post_rst.in_ready", 16'(in_ready), 16'd1);
    bus_rd(16'hFF03, 16'h0001, "status_after_rst");
    bus_rd(16'hFF04, 16'h0000, "timer_after_rst");

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 600; i++) begin
      logic [3:0] o;
      reset = ($urandom_range(0, 99) != 0);
      o = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      addr = ($urandom_range(0, 9) == 0) ? {12'hFE0, o} : {BASE[15:4], o};
      we = ($urandom_range(0, 3) == 0);
      oe = ($urandom_range(0, 2) == 0);
      wdata = (o == 4'h4) ? 16'($urandom_range(0, 12)) : 16'($urandom);
      in_valid = ($urandom_range(0, 1) == 0);
      in_data = 16'($urandom);
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
